simon_sequence_controller: RTL and testbench

Sequencer for the Simon game's colour pattern. It requests one random colour per round from the random number generator over a request/valid handshake and stores the growing sequence in an internal buffer. It then plays the whole sequence back as timed on/off colour pulses to the LED/display stage. It also exposes a read port so the player-input checker can compare presses against the stored sequence.

---
 rtl/simon_pkg.sv | 38 +++
 rtl/simon_sequence_controller_seq_mem.sv | 46 ++++
 rtl/simon_sequence_controller.sv | 195 +++++++++++++++++++
 tb/tb_simon_sequence_controller.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types, constants and colour/code helpers for the Simon sequence controller.
package simon_pkg;

  // Controller states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    PLAY_ON  = 3'd2,
    PLAY_OFF = 3'd3,
    WAIT     = 3'd4
  } seq_state_t;

  // Colour as seen on the display bus: 0 = dark, 1..4 = lit colour
  typedef logic [2:0] color_t;

  // Compact stored form of a colour: 0..3
  typedef logic [1:0] code_t;

  localparam color_t COLOR_DARK = 3'd0;

  // Only colours 1..4 are accepted from the generator
  function automatic logic is_legal_color(input color_t c);
    return (c >= 3'd1) && (c <= 3'd4);
  endfunction

  // Colour 1..4 -> stored code 0..3
  function automatic code_t color_to_code(input color_t c);
    color_t t;
    t = c - 3'd1;
    return t[1:0];
  endfunction

  // Stored code 0..3 -> colour 1..4
  function automatic color_t code_to_color(input code_t k);
    return color_t'({1'b0, k} + 3'd1);
  endfunction

endpackage

// File: rtl/simon_sequence_controller_seq_mem.sv
// Sequence buffer: DEPTH x 2-bit codes, synchronous write, two asynchronous reads.
// Reads at or beyond DEPTH return code 0; callers mask by length themselves.
module seq_mem
  import simon_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  code_t         wdata,
  input  logic [AW-1:0] play_idx,
  output code_t         play_code,
  input  logic [AW-1:0] rd_idx,
  output code_t         rd_code
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  code_t mem [DEPTH];

  // Write one code per accepted generator value
  always_ff @(posedge clk) begin
    if (we && (waddr < AW'(DEPTH))) begin
      mem[waddr[IW-1:0]] <= wdata;
    end
  end

  // Playback read port
  always_comb begin
    play_code = '0;
    if (play_idx < AW'(DEPTH)) begin
      play_code = mem[play_idx[IW-1:0]];
    end
  end

  // Checker read port
  always_comb begin
    rd_code = '0;
    if (rd_idx < AW'(DEPTH)) begin
      rd_code = mem[rd_idx[IW-1:0]];
    end
  end

endmodule

// File: rtl/simon_sequence_controller.sv
// Simon colour-sequence controller: requests one colour per round, stores the
// growing sequence and replays it as timed on/off pulses.
// Optional feature macro: SEQCTL_TIMEOUT_EN adds a generator response timeout
// and the sticky o_error output.
module simon_sequence_controller
  import simon_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 32,
  parameter int unsigned ON_CYCLES      = 50_000_000,
  parameter int unsigned OFF_CYCLES     = 25_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned LW             = $clog2(MAX_LEN + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_next_round,
  output logic          o_gen_req,
  input  logic          i_gen_valid,
  input  logic [2:0]    i_gen_value,
  output logic [2:0]    o_color,
  output logic          o_play_active,
  output logic          o_play_done,
  output logic          o_win,
  output logic [LW-1:0] o_length,
  output logic          o_full,
`ifdef SEQCTL_TIMEOUT_EN
  output logic          o_error,
`endif
  input  logic [LW-1:0] i_rd_idx,
  output logic [2:0]    o_rd_color
);

  localparam int unsigned DUR_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned CW      = (DUR_MAX > 1) ? $clog2(DUR_MAX + 1) : 1;

  seq_state_t    state;
  logic [LW-1:0] step;
  logic [CW-1:0] dur_cnt;

`ifdef SEQCTL_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [TW-1:0] tout_cnt;
`endif

  logic          gen_legal;
  logic          mem_we;
  logic [LW-1:0] len_inc;
  logic [LW-1:0] step_inc;
  logic [LW-1:0] play_idx;
  code_t         play_code;
  code_t         rd_code;

  assign gen_legal = is_legal_color(i_gen_value);
  assign mem_we    = (state == REQ) && !i_start && i_gen_valid && gen_legal;
  assign len_inc   = LW'(o_length + 1'b1);
  assign step_inc  = LW'(step + 1'b1);
  // Look ahead to the next colour while dark; otherwise point at the first one
  assign play_idx  = (state == PLAY_OFF) ? step_inc : '0;

  seq_mem #(
    .DEPTH (MAX_LEN),
    .AW    (LW)
  ) u_seq_mem (
    .clk       (i_clk),
    .we        (mem_we),
    .waddr     (o_length),
    .wdata     (color_to_code(i_gen_value)),
    .play_idx  (play_idx),
    .play_code (play_code),
    .rd_idx    (i_rd_idx),
    .rd_code   (rd_code)
  );

  // Checker read port, masked to the valid part of the sequence
  assign o_rd_color = (i_rd_idx < o_length) ? code_to_color(rd_code) : COLOR_DARK;

  // Sequencer FSM with duration counter and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      step          <= '0;
      dur_cnt       <= '0;
      o_gen_req     <= 1'b0;
      o_color       <= COLOR_DARK;
      o_play_active <= 1'b0;
      o_play_done   <= 1'b0;
      o_win         <= 1'b0;
      o_length      <= '0;
      o_full        <= 1'b0;
`ifdef SEQCTL_TIMEOUT_EN
      tout_cnt      <= '0;
      o_error       <= 1'b0;
`endif
    end else begin
      o_play_done <= 1'b0;
      o_win       <= 1'b0;
      if (i_start) begin
        state         <= REQ;
        step          <= '0;
        dur_cnt       <= '0;
        o_gen_req     <= 1'b1;
        o_color       <= COLOR_DARK;
        o_play_active <= 1'b0;
        o_length      <= '0;
        o_full        <= 1'b0;
`ifdef SEQCTL_TIMEOUT_EN
        tout_cnt      <= '0;
        o_error       <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            o_gen_req <= 1'b0;
          end

          REQ: begin
            if (i_gen_valid && gen_legal) begin
              state         <= PLAY_ON;
              step          <= '0;
              dur_cnt       <= CW'(ON_CYCLES - 1);
              o_gen_req     <= 1'b0;
              o_play_active <= 1'b1;
              o_length      <= len_inc;
              o_full        <= (len_inc == LW'(MAX_LEN));
              // First round: index 0 is being written this cycle
              o_color       <= (o_length == '0) ? i_gen_value : code_to_color(play_code);
            end
`ifdef SEQCTL_TIMEOUT_EN
            else if (tout_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
              state     <= IDLE;
              o_gen_req <= 1'b0;
              o_error   <= 1'b1;
            end else begin
              tout_cnt <= TW'(tout_cnt + 1'b1);
            end
`else
            else begin
              o_gen_req <= 1'b1;
            end
`endif
          end

          PLAY_ON: begin
            if (dur_cnt == '0) begin
              state   <= PLAY_OFF;
              dur_cnt <= CW'(OFF_CYCLES - 1);
              o_color <= COLOR_DARK;
            end else begin
              dur_cnt <= CW'(dur_cnt - 1'b1);
            end
          end

          PLAY_OFF: begin
            if (dur_cnt == '0) begin
              if (step_inc < o_length) begin
                state   <= PLAY_ON;
                step    <= step_inc;
                dur_cnt <= CW'(ON_CYCLES - 1);
                o_color <= code_to_color(play_code);
              end else begin
                state         <= WAIT;
                o_play_active <= 1'b0;
                o_play_done   <= 1'b1;
              end
            end else begin
              dur_cnt <= CW'(dur_cnt - 1'b1);
            end
          end

          WAIT: begin
            if (i_next_round) begin
              if (o_full) begin
                o_win <= 1'b1;
              end else begin
                state     <= REQ;
                o_gen_req <= 1'b1;
`ifdef SEQCTL_TIMEOUT_EN
                tout_cnt  <= '0;
`endif
              end
            end
          end

          default: begin
            state     <= IDLE;
            o_gen_req <= 1'b0;
            o_color   <= COLOR_DARK;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_simon_sequence_controller.sv
// Randomised scoreboard bench for simon_sequence_controller.
module tb_simon_sequence_controller;

  localparam int MAX_LEN = 4;
  localparam int ON_C    = 3;
  localparam int OFF_C   = 2;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic          clk;
  logic          rst;
  logic          start;
  logic          next_round;
  logic          gen_req;
  logic          gen_valid;
  logic [2:0]    gen_value;
  logic [2:0]    color;
  logic          play_active;
  logic          play_done;
  logic          win;
  logic [LW-1:0] length;
  logic          full;
  logic [LW-1:0] rd_idx;
  logic [2:0]    rd_color;
`ifdef SEQCTL_TIMEOUT_EN
  logic          error;
`endif

  simon_sequence_controller #(
    .MAX_LEN        (MAX_LEN),
    .ON_CYCLES      (ON_C),
    .OFF_CYCLES     (OFF_C),
    .TIMEOUT_CYCLES (1024)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_next_round  (next_round),
    .o_gen_req     (gen_req),
    .i_gen_valid   (gen_valid),
    .i_gen_value   (gen_value),
    .o_color       (color),
    .o_play_active (play_active),
    .o_play_done   (play_done),
    .o_win         (win),
    .o_length      (length),
    .o_full        (full),
`ifdef SEQCTL_TIMEOUT_EN
    .o_error       (error),
`endif
    .i_rd_idx      (rd_idx),
    .o_rd_color    (rd_color)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the stored sequence as a plain list of colours
  int model[$];
  // Scoreboard queues filled by stimulus, drained by the monitor
  int exp_len[$];
  int exp_trace[$];
  int exp_win[$];
  int exp_done = 0;
  int done_cnt = 0;
  int trace[$];

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Monitor: collect playback trace, compare on play_done / win pulses
  always @(negedge clk) begin
    if (!rst) begin
      if (play_active) trace.push_back(int'(color));
      if (play_done) begin
        if (exp_len.size() == 0) begin
          check("unexpected_play_done", 1, 0);
        end else begin
          int l;
          int n;
          bit ok;
          l  = exp_len.pop_front();
          n  = l * (ON_C + OFF_C);
          ok = (trace.size() == n);
          for (int i = 0; i < n; i++) begin
            int e;
            e = (exp_trace.size() > 0) ? exp_trace.pop_front() : -1;
            if (i >= trace.size() || trace[i] != e) ok = 1'b0;
          end
          if (!ok) $display("FAIL trace_detail: got %0d cycles expected %0d", trace.size(), n);
          check("playback_trace", int'(ok), 1);
          check("done_length", int'(length), l);
          check("done_color", int'(color), 0);
        end
        trace.delete();
        done_cnt++;
      end else if (!play_active) begin
        trace.delete();
      end
      if (win) begin
        if (exp_win.size() == 0) check("unexpected_win", 1, 0);
        else check("win_length", int'(length), exp_win.pop_front());
      end
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model.delete();
    check("start_gen_req", int'(gen_req), 1);
    check("start_length", int'(length), 0);
    check("start_color", int'(color), 0);
  endtask

  task automatic wait_req();
    int b = 0;
    while (!gen_req && b < 100) begin
      @(negedge clk);
      b++;
    end
    check("gen_req_seen", int'(gen_req), 1);
  endtask

  task automatic gen_send(input int v, input int dly);
    bit legal;
    wait_req();
    repeat (dly) @(negedge clk);
    legal = (v >= 1 && v <= 4);
    if (legal) begin
      model.push_back(v);
      exp_len.push_back(model.size());
      foreach (model[i]) begin
        repeat (ON_C) exp_trace.push_back(model[i]);
        repeat (OFF_C) exp_trace.push_back(0);
      end
      exp_done++;
    end
    gen_valid = 1'b1;
    gen_value = 3'(v);
    @(negedge clk);
    gen_valid = 1'b0;
    gen_value = 3'd0;
    if (legal) begin
      check("gen_req_drop", int'(gen_req), 0);
      check("first_color_lit", int'(color), model[0]);
      check("length_inc", int'(length), model.size());
      check("full_flag", int'(full), int'(model.size() == MAX_LEN));
    end else begin
      check("gen_req_held", int'(gen_req), 1);
      check("length_hold", int'(length), model.size());
    end
  endtask

  task automatic wait_done();
    int b = 0;
    while (done_cnt != exp_done && b < 200) begin
      @(negedge clk);
      b++;
    end
    check("play_done_seen", done_cnt, exp_done);
  endtask

  task automatic do_next();
    bit is_full;
    is_full = (model.size() == MAX_LEN);
    if (is_full) exp_win.push_back(model.size());
    @(negedge clk);
    next_round = 1'b1;
    @(negedge clk);
    next_round = 1'b0;
    check("next_gen_req", int'(gen_req), int'(!is_full));
    check("next_length", int'(length), model.size());
  endtask

  task automatic check_rd(input int idx);
    rd_idx = LW'(idx);
    #1;
    check("rd_color", int'(rd_color), (idx < model.size()) ? model[idx] : 0);
  endtask

  function automatic int rand_illegal();
    int pick;
    pick = int'($urandom_range(0, 3));
    return (pick == 0) ? 0 : pick + 4;
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; next_round = 1'b0;
    gen_valid = 1'b0; gen_value = 3'd0; rd_idx = '0;
    repeat (3) @(negedge clk);
    check("rst_gen_req", int'(gen_req), 0);
    check("rst_color", int'(color), 0);
    check("rst_play_active", int'(play_active), 0);
    check("rst_length", int'(length), 0);
    check("rst_full", int'(full), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_gen_req", int'(gen_req), 0);

    // Single round, generator answers 3 after two cycles
    do_start();
    gen_send(3, 2);
    wait_done();
    check("round1_length", int'(length), 1);

    // Three rounds 2,4,1 and read port
    do_start();
    gen_send(2, 0);
    wait_done();
    do_next();
    gen_send(4, 1);
    wait_done();
    do_next();
    gen_send(1, 3);
    wait_done();
    for (int i = 0; i < 4; i++) check_rd(i);

    // Generator value ignored outside REQ
    @(negedge clk);
    gen_valid = 1'b1; gen_value = 3'd2;
    @(negedge clk);
    gen_valid = 1'b0; gen_value = 3'd0;
    check("valid_ignored_len", int'(length), 3);
    check("valid_ignored_active", int'(play_active), 0);

    // Illegal values discarded, then 4 stored (fills the buffer)
    do_next();
    gen_send(0, 0);
    gen_send(6, 1);
    gen_send(4, 0);
    wait_done();
    check("full_after_fill", int'(full), 1);

    // Full buffer: next round produces a win and nothing else
    do_next();
    @(negedge clk);
    check("win_no_req", int'(gen_req), 0);
    check("win_len_stays", int'(length), MAX_LEN);

    // Randomised games
    for (int g = 0; g < 3; g++) begin
      do_start();
      while (model.size() < MAX_LEN) begin
        if (model.size() > 0) do_next();
        repeat ($urandom_range(0, 2)) gen_send(rand_illegal(), int'($urandom_range(0, 2)));
        gen_send(int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
        wait_done();
        check_rd(int'($urandom_range(0, 7)));
        check_rd(int'($urandom_range(0, MAX_LEN)));
      end
      do_next();
    end

    // Start during PLAY_ON at length 3, with next_round in the same cycle
    do_start();
    gen_send(1, 0);
    wait_done();
    do_next();
    gen_send(2, 0);
    wait_done();
    do_next();
    gen_send(3, 0);
    start = 1'b1;
    next_round = 1'b1;
    @(negedge clk);
    start = 1'b0;
    next_round = 1'b0;
    exp_len.delete();
    exp_trace.delete();
    exp_done--;
    model.delete();
    check("abort_length", int'(length), 0);
    check("abort_gen_req", int'(gen_req), 1);
    check("abort_color", int'(color), 0);
    check("abort_active", int'(play_active), 0);
    gen_send(4, 0);
    wait_done();
    check("abort_restart_len", int'(length), 1);

    // Asynchronous reset mid-playback
    do_next();
    gen_send(2, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_color", int'(color), 0);
    check("async_rst_active", int'(play_active), 0);
    check("async_rst_length", int'(length), 0);
    exp_len.delete();
    exp_trace.delete();
    exp_done--;
    model.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle_req", int'(gen_req), 0);

    check("pending_done", exp_len.size(), 0);
    check("pending_win", exp_win.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
